// File: rtl/vend_controller.sv
// Multi-product vending sequencer: coin credit, price/stock validated
// selection, dispenser req/done handshake, unit-coin change via req/ack,
// cancel and inactivity-timeout refunds. All outputs are registered.
module vend_controller #(
    parameter int unsigned CREDIT_W   = 4,
    parameter int unsigned MAX_CREDIT = 15,
    parameter int unsigned PRICE0     = 3,
    parameter int unsigned PRICE1     = 4,
    parameter int unsigned PRICE2     = 5,
    parameter int unsigned PRICE3     = 6,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_val,
    input  logic                sel_valid,
    input  logic [1:0]          sel,
    input  logic                cancel,
    input  logic [3:0]          stock_empty,
    input  logic                disp_done,
    input  logic                chg_ack,
    output logic                disp_req,
    output logic [1:0]          disp_sel,
    output logic                chg_req,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                sel_reject,
    output logic                busy
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT);

    localparam logic [CREDIT_W:0]   MAX_SUM    = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] P0         = CREDIT_W'(PRICE0);
    localparam logic [CREDIT_W-1:0] P1         = CREDIT_W'(PRICE1);
    localparam logic [CREDIT_W-1:0] P2         = CREDIT_W'(PRICE2);
    localparam logic [CREDIT_W-1:0] P3         = CREDIT_W'(PRICE3);
    localparam logic [CREDIT_W-1:0] ONE        = CREDIT_W'(1);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CREDIT   = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    state_t               state;
    logic [TIMER_W-1:0]   timer;

    logic [CREDIT_W-1:0]  coin_amt;
    logic [CREDIT_W:0]    coin_sum;
    logic                 coin_fits;
    logic [CREDIT_W-1:0]  sel_price;
    logic                 sel_ok;

    // Coin value decode, overflow-free sum, and selection price/stock check
    always_comb begin
        coin_amt = '0;
        case (coin_val)
            2'b01:   coin_amt = CREDIT_W'(1);
            2'b10:   coin_amt = CREDIT_W'(2);
            default: coin_amt = '0;
        endcase
        coin_sum  = {1'b0, credit} + {1'b0, coin_amt};
        coin_fits = (coin_amt != '0) && (coin_sum <= MAX_SUM);

        case (sel)
            2'd0:    sel_price = P0;
            2'd1:    sel_price = P1;
            2'd2:    sel_price = P2;
            default: sel_price = P3;
        endcase
        sel_ok = !stock_empty[sel] && (credit >= sel_price);
    end

    // Sequencer: state, credit, timer and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            credit      <= '0;
            disp_req    <= 1'b0;
            disp_sel    <= 2'd0;
            chg_req     <= 1'b0;
            coin_reject <= 1'b0;
            sel_reject  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            sel_reject  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (coin_valid) begin
                        if (coin_fits) begin
                            credit <= coin_sum[CREDIT_W-1:0];
                            timer  <= '0;
                            state  <= S_CREDIT;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                    if (sel_valid) begin
                        sel_reject <= 1'b1;
                    end
                end

                S_CREDIT: begin
                    if (cancel) begin
                        coin_reject <= coin_valid;
                        timer       <= '0;
                        chg_req     <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_CHANGE;
                    end else if (sel_valid) begin
                        coin_reject <= coin_valid;
                        timer       <= '0;
                        if (sel_ok) begin
                            credit   <= credit - sel_price;
                            disp_sel <= sel;
                            disp_req <= 1'b1;
                            busy     <= 1'b1;
                            state    <= S_DISPENSE;
                        end else begin
                            sel_reject <= 1'b1;
                        end
                    end else if (coin_valid) begin
                        timer <= '0;
                        if (coin_fits) begin
                            credit <= coin_sum[CREDIT_W-1:0];
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end else if (timer == TIMER_LAST) begin
                        chg_req <= 1'b1;
                        busy    <= 1'b1;
                        state   <= S_CHANGE;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end

                S_DISPENSE: begin
                    coin_reject <= coin_valid;
                    sel_reject  <= sel_valid;
                    if (disp_done) begin
                        disp_req <= 1'b0;
                        if (credit != '0) begin
                            chg_req <= 1'b1;
                            state   <= S_CHANGE;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end

                S_CHANGE: begin
                    coin_reject <= coin_valid;
                    sel_reject  <= sel_valid;
                    if (chg_ack) begin
                        credit <= credit - ONE;
                        // Last unit paid: drop the request on this same edge
                        if (credit == ONE) begin
                            chg_req <= 1'b0;
                            busy    <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios followed by
// randomized traffic, all checked every cycle against a behavioural model.
module tb_vend_controller;

    localparam int CW      = 4;
    localparam int MAXC    = 15;
    localparam int TMO     = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          coin_valid;
    logic [1:0]    coin_val;
    logic          sel_valid;
    logic [1:0]    sel;
    logic          cancel;
    logic [3:0]    stock_empty;
    logic          disp_done;
    logic          chg_ack;
    logic          disp_req;
    logic [1:0]    disp_sel;
    logic          chg_req;
    logic [CW-1:0] credit;
    logic          coin_reject;
    logic          sel_reject;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    vend_controller #(
        .CREDIT_W  (CW),
        .MAX_CREDIT(MAXC),
        .PRICE0    (3),
        .PRICE1    (4),
        .PRICE2    (5),
        .PRICE3    (6),
        .TIMEOUT   (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .coin_valid (coin_valid),
        .coin_val   (coin_val),
        .sel_valid  (sel_valid),
        .sel        (sel),
        .cancel     (cancel),
        .stock_empty(stock_empty),
        .disp_done  (disp_done),
        .chg_ack    (chg_ack),
        .disp_req   (disp_req),
        .disp_sel   (disp_sel),
        .chg_req    (chg_req),
        .credit     (credit),
        .coin_reject(coin_reject),
        .sel_reject (sel_reject),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: machine phase plus plain integer bookkeeping
    localparam int M_IDLE = 0;
    localparam int M_CREDIT = 1;
    localparam int M_DISP = 2;
    localparam int M_CHG = 3;

    int price [4] = '{3, 4, 5, 6};
    int m_mode = M_IDLE;
    int m_credit = 0;
    int m_idle_cnt = 0;
    int m_disp_req = 0;
    int m_disp_sel = 0;
    int m_chg_req = 0;
    int m_coin_rej = 0;
    int m_sel_rej = 0;
    logic [3:0] stk = 4'b0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply a coin to the model's credit if it fits; otherwise it bounces
    task automatic model_coin();
        int amt;
        amt = (coin_val == 2'b01) ? 1 : (coin_val == 2'b10) ? 2 : 0;
        if (amt > 0 && m_credit + amt <= MAXC) begin
            m_credit += amt;
            if (m_mode == M_IDLE) begin
                m_mode = M_CREDIT;
                m_idle_cnt = 0;
            end
        end else begin
            m_coin_rej = 1;
        end
    endtask

    task automatic model_step();
        m_coin_rej = 0;
        m_sel_rej = 0;
        if (rst) begin
            m_mode = M_IDLE; m_credit = 0; m_idle_cnt = 0;
            m_disp_req = 0; m_disp_sel = 0; m_chg_req = 0;
            return;
        end
        if (m_mode == M_IDLE) begin
            if (coin_valid) model_coin();
            if (sel_valid) m_sel_rej = 1;
        end else if (m_mode == M_CREDIT) begin
            if (cancel) begin
                m_coin_rej = int'(coin_valid);
                m_mode = M_CHG; m_chg_req = 1;
            end else if (sel_valid) begin
                m_coin_rej = int'(coin_valid);
                m_idle_cnt = 0;
                if (stock_empty[sel] || m_credit < price[sel]) begin
                    m_sel_rej = 1;
                end else begin
                    m_credit -= price[sel];
                    m_disp_sel = int'(sel);
                    m_disp_req = 1;
                    m_mode = M_DISP;
                end
            end else if (coin_valid) begin
                m_idle_cnt = 0;
                model_coin();
            end else begin
                m_idle_cnt++;
                if (m_idle_cnt == TMO) begin
                    m_mode = M_CHG; m_chg_req = 1;
                end
            end
        end else if (m_mode == M_DISP) begin
            m_coin_rej = int'(coin_valid);
            m_sel_rej = int'(sel_valid);
            if (disp_done) begin
                m_disp_req = 0;
                if (m_credit > 0) begin
                    m_mode = M_CHG; m_chg_req = 1;
                end else begin
                    m_mode = M_IDLE;
                end
            end
        end else begin
            m_coin_rej = int'(coin_valid);
            m_sel_rej = int'(sel_valid);
            if (chg_ack) begin
                m_credit--;
                if (m_credit == 0) begin
                    m_chg_req = 0; m_mode = M_IDLE;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("credit", 32'(credit), 32'(m_credit));
        check("disp_req", 32'(disp_req), 32'(m_disp_req));
        if (m_disp_req != 0) check("disp_sel", 32'(disp_sel), 32'(m_disp_sel));
        check("chg_req", 32'(chg_req), 32'(m_chg_req));
        check("coin_reject", 32'(coin_reject), 32'(m_coin_rej));
        check("sel_reject", 32'(sel_reject), 32'(m_sel_rej));
        check("busy", 32'(busy), (m_mode == M_DISP || m_mode == M_CHG) ? 32'd1 : 32'd0);
    endtask

    // One clock: drive at negedge, model the edge, compare at next negedge
    task automatic cycle(input logic r, input logic cv, input logic [1:0] cval,
                         input logic sv, input logic [1:0] s, input logic c,
                         input logic [3:0] st, input logic d, input logic a);
        rst = r; coin_valid = cv; coin_val = cval; sel_valid = sv; sel = s;
        cancel = c; stock_empty = st; disp_done = d; chg_ack = a;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 1'b0, stk, 1'b0, 1'b0);
    endtask
    task automatic coin_in(input logic [1:0] v);
        cycle(1'b0, 1'b1, v, 1'b0, 2'd0, 1'b0, stk, 1'b0, 1'b0);
    endtask
    task automatic sel_in(input logic [1:0] s);
        cycle(1'b0, 1'b0, 2'b00, 1'b1, s, 1'b0, stk, 1'b0, 1'b0);
    endtask
    task automatic cancel_in();
        cycle(1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 1'b1, stk, 1'b0, 1'b0);
    endtask
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 1'b0, stk, 1'b0, 1'b0);
    endtask
    task automatic done_in();
        cycle(1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 1'b0, stk, 1'b1, 1'b0);
    endtask
    task automatic ack_in(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 1'b0, stk, 1'b0, 1'b1);
    endtask

    initial begin
        int rate;
        logic r, cv, sv, c, d, a;
        logic [1:0] cval, s;
        logic [3:0] st;

        rst = 1'b1; coin_valid = 1'b0; coin_val = 2'b00; sel_valid = 1'b0; sel = 2'd0;
        cancel = 1'b0; stock_empty = 4'b0000; disp_done = 1'b0; chg_ack = 1'b0;
        @(negedge clk);
        do_reset();
        check("rst_credit", 32'(credit), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Exact-credit purchase, no change
        coin_in(2'b10); coin_in(2'b10);
        check("exact_credit", 32'(credit), 32'd4);
        sel_in(2'd1);
        check("exact_req", 32'(disp_req), 32'd1);
        check("exact_sel", 32'(disp_sel), 32'd1);
        check("exact_left", 32'(credit), 32'd0);
        idle(2);
        done_in();
        check("exact_done_req", 32'(disp_req), 32'd0);
        check("exact_no_chg", 32'(chg_req), 32'd0);
        check("exact_idle", 32'(busy), 32'd0);

        // Purchase with change
        coin_in(2'b10); coin_in(2'b10); coin_in(2'b10); coin_in(2'b01);
        check("chg_credit7", 32'(credit), 32'd7);
        sel_in(2'd0);
        check("chg_credit4", 32'(credit), 32'd4);
        done_in();
        check("chg_req_on", 32'(chg_req), 32'd1);
        ack_in(3);
        check("chg_credit1", 32'(credit), 32'd1);
        check("chg_req_held", 32'(chg_req), 32'd1);
        ack_in(1);
        check("chg_credit0", 32'(credit), 32'd0);
        check("chg_req_off", 32'(chg_req), 32'd0);

        // Saturation and invalid coin
        for (int k = 0; k < 7; k++) coin_in(2'b10);
        check("sat_14", 32'(credit), 32'd14);
        coin_in(2'b10);
        check("sat_rej", 32'(coin_reject), 32'd1);
        check("sat_hold", 32'(credit), 32'd14);
        coin_in(2'b01);
        check("sat_15", 32'(credit), 32'd15);
        check("sat_rej_pulse", 32'(coin_reject), 32'd0);
        coin_in(2'b11);
        check("bad_coin_rej", 32'(coin_reject), 32'd1);
        cancel_in();
        ack_in(15);
        check("sat_drained", 32'(busy), 32'd0);

        // Selection refusals
        coin_in(2'b10);
        sel_in(2'd3);
        check("poor_rej", 32'(sel_reject), 32'd1);
        check("poor_credit", 32'(credit), 32'd2);
        coin_in(2'b10); coin_in(2'b10); coin_in(2'b10); coin_in(2'b01);
        check("stock_credit9", 32'(credit), 32'd9);
        stk = 4'b0100;
        sel_in(2'd2);
        check("stock_rej", 32'(sel_reject), 32'd1);
        stk = 4'b0000;
        cancel_in();
        ack_in(9);
        sel_in(2'd0);
        check("idle_sel_rej", 32'(sel_reject), 32'd1);

        // Cancel with ack held high pays one unit per cycle
        coin_in(2'b10); coin_in(2'b10); coin_in(2'b01);
        cancel_in();
        check("cancel_chg", 32'(chg_req), 32'd1);
        for (int k = 4; k >= 0; k--) begin
            ack_in(1);
            check("refund_step", 32'(credit), 32'(k));
        end
        check("refund_idle", 32'(busy), 32'd0);

        // Inactivity timeout
        coin_in(2'b10); coin_in(2'b01);
        idle(TMO - 1);
        check("tmo_wait", 32'(busy), 32'd0);
        idle(1);
        check("tmo_fire", 32'(chg_req), 32'd1);

        // Reset in the middle of change
        ack_in(1);
        check("mid_credit", 32'(credit), 32'd2);
        do_reset();
        check("rst_mid_credit", 32'(credit), 32'd0);
        check("rst_mid_chg", 32'(chg_req), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        coin_in(2'b01);
        check("post_rst_coin", 32'(credit), 32'd1);

        // Randomized traffic; activity rate varies per block so timeouts occur
        for (int blk = 0; blk < 16; blk++) begin
            rate = $urandom_range(2, 30);
            for (int i = 0; i < 250; i++) begin
                r    = ($urandom_range(0, 299) == 0);
                cv   = ($urandom_range(0, rate - 1) == 0);
                cval = 2'($urandom_range(0, 3));
                sv   = ($urandom_range(0, 3 * rate) == 0);
                s    = 2'($urandom_range(0, 3));
                c    = ($urandom_range(0, 12 * rate) == 0);
                if (sv && c) sv = 1'b0;
                st   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
                d    = ($urandom_range(0, 3) == 0);
                a    = ($urandom_range(0, 2) == 0);
                cycle(r, cv, cval, sv, s, c, st, d, a);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
